increment_16bit_counter: RTL and testbench
==========================================

// Module: increment_16bit_counter
// PURPOSE
// - Registered 16-bit incrementer: the counting-up counterpart of the 16-bit decrement path.
// - Holds a value that advances by STEP on each enabled clock. Supports synchronous clear and parallel load.
// - Reports unsigned carry-out, two's-complement signed overflow (sticky), and a terminal-count match.
// - Used as the up-counting register (PC / loop index) alongside the ALU datapath.
// PARAMETERS
// - WIDTH   16      datapath width; all value ports are WIDTH bits
// - STEP    1       increment amount per enabled cycle, unsigned, 1..2**(WIDTH-1)-1
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      asynchronous active-low reset
// - clr        in   1      synchronous clear request
// - load       in   1      synchronous parallel load request
// - load_val   in   WIDTH  value captured on load
// - en         in   1      increment enable
// - tc_val     in   WIDTH  terminal-count compare value
// - count      out  WIDTH  current counter value (registered)
// - carry      out  1      1-cycle pulse: unsigned wrap occurred on the last update
// - overflow   out  1      sticky: signed overflow occurred since last clr/load/reset
// - tc_hit     out  1      1-cycle pulse: count became equal to tc_val on the last increment
// BEHAVIOUR
// - Reset (rst_n=0, async): count=0, carry=0, overflow=0, tc_hit=0. Outputs hold while rst_n is low.
//   Release is synchronous-safe: the first update occurs on the first rising clk with rst_n=1.
// - Update priority each rising edge: clr > load > en > hold.
//   - clr: count<=0, overflow<=0, carry<=0, tc_hit<=0.
//   - load: count<=load_val, overflow<=0, carry<=0, tc_hit<=0.
//   - en: sum = {1'b0,count} + STEP (WIDTH+1 bits).
//     - count<=sum[WIDTH-1:0]; carry<=sum[WIDTH].
//     - overflow<=overflow | (~count[WIDTH-1] & sum[WIDTH-1]), i.e. a positive value crossed into negative.
//     - tc_hit<=(sum[WIDTH-1:0]==tc_val).
//   - hold (no request): count unchanged; carry<=0, tc_hit<=0; overflow unchanged.
// - Latency: new count is visible 1 cycle after the request edge. carry and tc_hit are registered and aligned with that count.
// - carry and tc_hit are never asserted for two cycles unless en is held and the condition recurs.
// - Wrap-around: 0xFFFF + 1 -> 0x0000 with carry=1. Overflow is not set, since the signed value goes -1 -> 0.
// - Signed boundary: 0x7FFF + 1 -> 0x8000 with overflow set (sticky) and carry=0.
// - clr together with load or en: clr wins and the other requests are ignored.
// - load together with en: the loaded value is taken and is not incremented that cycle.
// - tc_val changes affect only the next increment comparison. Load/clr never raise tc_hit.
// - Reset asserted mid-count: immediate return to reset values. No partial update is retained.
// CONFIGURATION
// - Macro INC_SATURATE_EN.
// - Defined: unsigned saturation.
//   - With en at count=0xFFFF (or any value where sum[WIDTH]=1), count<=all-ones and carry<=1 (flags saturation).
//   - tc_hit is evaluated against the saturated value.
//   - Overflow rule is unchanged.
// - Undefined (default): modular wrap as described in BEHAVIOUR.
// - Either way, port list and reset values are identical.
// TESTING
// - Reset: rst_n=0 mid-cycle with count=0x1234 -> count=0, flags=0 immediately, without waiting for a clk edge.
// - Count: load 0x0010, then en for 3 cycles -> count=0x0011, 0x0012, 0x0013; carry=0, overflow=0.
// - Wrap: load 0xFFFE, en x2 -> 0xFFFF, then 0x0000 with carry pulse=1 for 1 cycle.
//   - With INC_SATURATE_EN: 0xFFFF held, carry=1.
// - Signed overflow: load 0x7FFF, en -> count=0x8000, overflow=1.
//   - Further en keeps overflow=1; a subsequent clr -> overflow=0, count=0.
// - Priority: clr=load=en=1 -> count=0. Then load=en=1, load_val=0x00A0 -> count=0x00A0, not 0x00A1.
// - Terminal count: tc_val=0x0005, load 0x0003, en x3 -> tc_hit=1 only in the cycle count=0x0005, 0 otherwise.

Source files
------------

// File: rtl/increment_16bit_counter.sv
// -----------------------------------------------------------------------------
// increment_16bit_counter
//
// A registered up-counter that adds STEP on each enabled clock. It is the
// up-counting register (PC / loop index) used next to the ALU datapath.
//
// Update priority on every rising clk edge: clr > load > en > hold.
//   count    : current value (registered)
//   carry    : 1-cycle pulse, unsigned wrap (or saturation) on the last update
//   overflow : sticky, a non-negative value stepped into the negative range;
//              cleared only by clr, load or reset
//   tc_hit   : 1-cycle pulse, an increment produced a value equal to tc_val
//
// Build option:
//   INC_SATURATE_EN  when defined, an increment that would wrap past all-ones
//                    leaves count at all-ones and still pulses carry. When it
//                    is undefined (default), the counter wraps modulo 2**WIDTH.
//   The port list and the reset values are the same in both builds.
// -----------------------------------------------------------------------------
module increment_16bit_counter #(
  parameter int unsigned WIDTH = 16,
  // Legal range is 1 .. 2**(WIDTH-1)-1.
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] tc_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             overflow,
  output logic             tc_hit
);

  // STEP widened to the WIDTH+1 bit adder so the carry-out lands in the top bit.
  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  // State registers and their next-state values.
  logic [WIDTH-1:0] count_q,    count_d;
  logic             carry_q,    carry_d;
  logic             overflow_q, overflow_d;
  logic             tc_hit_q,   tc_hit_d;

  // Increment datapath.
  logic [WIDTH:0]   sum;        // raw {carry, value} sum
  logic [WIDTH-1:0] inc_val;    // value the counter takes on an increment
  logic             inc_carry;  // carry reported for that increment
  logic             inc_ovf;    // non-negative value became negative

  assign sum       = {1'b0, count_q} + STEP_EXT;
  assign inc_carry = sum[WIDTH];

  // The overflow rule looks at the raw sum in both builds, so saturation does
  // not change when overflow is flagged.
  assign inc_ovf   = ~count_q[WIDTH-1] & sum[WIDTH-1];

`ifdef INC_SATURATE_EN
  // Saturating build: stop at all-ones. tc_hit compares the saturated value.
  assign inc_val = inc_carry ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
  // Default build: wrap modulo 2**WIDTH.
  assign inc_val = sum[WIDTH-1:0];
`endif

  // Next-state selection: clr > load > en > hold.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no
    // path through the if/else chain can leave a signal unassigned and infer a
    // latch.
    count_d    = count_q;
    carry_d    = 1'b0;
    overflow_d = overflow_q;
    tc_hit_d   = 1'b0;

    if (clr) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (load) begin
      count_d    = load_val;
      overflow_d = 1'b0;
    end else if (en) begin
      count_d    = inc_val;
      carry_d    = inc_carry;
      overflow_d = overflow_q | inc_ovf;
      tc_hit_d   = (inc_val == tc_val);
    end
  end

  // State flops, cleared asynchronously when rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      tc_hit_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop in this block samples the
      // values from before the edge. Blocking assignments here would let one
      // flop see another flop's new value within the same edge.
      count_q    <= count_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      tc_hit_q   <= tc_hit_d;
    end
  end

  // The outputs are the registered state, with no logic after the flops.
  assign count    = count_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign tc_hit   = tc_hit_q;

endmodule

// File: tb/tb_increment_16bit_counter.sv
// -----------------------------------------------------------------------------
// tb_increment_16bit_counter
//
// A scoreboard bench. The stimulus process drives the inputs on the falling
// edge. It advances a plain-integer reference model and pushes the expected
// {count, carry, overflow, tc_hit} into a queue. The monitor wakes 1 time unit
// after each rising edge, pops one entry and compares it with the DUT outputs.
// Reset behaviour is compared directly while rst_n is held low.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_increment_16bit_counter;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned STEP  = 1;
  localparam int unsigned MODV  = 1 << WIDTH;   // 65536

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] tc_val;
  logic [WIDTH-1:0] count;
  logic             carry;
  logic             overflow;
  logic             tc_hit;

  increment_16bit_counter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .tc_val   (tc_val),
    .count    (count),
    .carry    (carry),
    .overflow (overflow),
    .tc_hit   (tc_hit)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected DUT outputs after one rising edge.
  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic             carry;
    logic             overflow;
    logic             tc_hit;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference-model state, kept as plain integers.
  int unsigned m_count = 0;
  bit          m_ovf   = 0;

  // Compares one observed value with its expected value and records the result.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model. It works from the counter's arithmetic meaning: a
  // numeric sum, unsigned wrap or saturation, and signed value ranges.
  function automatic exp_t model(input bit c, input bit l, input int unsigned lv,
                                 input bit e, input int unsigned tv);
    exp_t        r;
    int unsigned nxt;
    int          s_old;
    bit          cy;
    bit          th;
    cy = 0;
    th = 0;
    if (c) begin
      m_count = 0;
      m_ovf   = 0;
    end else if (l) begin
      m_count = lv;
      m_ovf   = 0;
    end else if (e) begin
      nxt   = m_count + STEP;
      s_old = (m_count >= MODV/2) ? int'(m_count) - int'(MODV) : int'(m_count);
      if (s_old >= 0 && s_old + int'(STEP) > int'(MODV/2) - 1) m_ovf = 1;
      cy = (nxt >= MODV);
`ifdef INC_SATURATE_EN
      m_count = cy ? MODV - 1 : nxt;
`else
      m_count = nxt % MODV;
`endif
      th = (m_count == tv);
    end
    r.count    = WIDTH'(m_count);
    r.carry    = cy;
    r.overflow = m_ovf;
    r.tc_hit   = th;
    return r;
  endfunction

  // Drives one cycle of requests on the falling edge and queues the response
  // expected after the following rising edge.
  task automatic drive(input bit c, input bit l, input logic [WIDTH-1:0] lv,
                       input bit e, input logic [WIDTH-1:0] tv);
    @(negedge clk);
    clr      = c;
    load     = l;
    load_val = lv;
    en       = e;
    tc_val   = tv;
    exp_q.push_back(model(c, l, int'(lv), e, int'(tv)));
  endtask

  // Monitor: on every rising edge with a queued entry, pops and compares it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", {13'd0, count, carry, overflow, tc_hit},
                       {13'd0, e.count, e.carry, e.overflow, e.tc_hit});
      end
    end
  end

  // Holds reset across two rising edges with requests active. Outputs must
  // stay zero the whole time.
  task automatic reset_hold();
    clr = 1'b0; load = 1'b1; load_val = 16'h5555; en = 1'b1; tc_val = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_hold", {13'd0, count, carry, overflow, tc_hit}, 32'd0);
    end
    @(negedge clk);
    load = 1'b0; en = 1'b0;
    rst_n = 1'b1;
    m_count = 0;
    m_ovf   = 0;
  endtask

  initial begin
    int unsigned r;
    logic [WIDTH-1:0] lv;
    logic [WIDTH-1:0] tv;
    bit c, l, e;

    rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; tc_val = '0;
    #2;
    check("rst_init", {13'd0, count, carry, overflow, tc_hit}, 32'd0);
    reset_hold();

    // Load 0x0010, then three increments.
    drive(0, 1, 16'h0010, 0, 16'h0000);
    repeat (3) drive(0, 0, 16'h0000, 1, 16'h0000);

    // Wrap from 0xFFFE (saturates instead when INC_SATURATE_EN is defined).
    drive(0, 1, 16'hFFFE, 0, 16'h0000);
    repeat (2) drive(0, 0, 16'h0000, 1, 16'h0000);
    drive(0, 0, 16'h0000, 0, 16'h0000);   // carry pulse must drop

    // Signed overflow and its sticky behaviour, then clr.
    drive(0, 1, 16'h7FFF, 0, 16'h0000);
    drive(0, 0, 16'h0000, 1, 16'h0000);
    drive(0, 0, 16'h0000, 1, 16'h0000);
    drive(0, 0, 16'h0000, 0, 16'h0000);
    drive(1, 0, 16'h0000, 0, 16'h0000);

    // Priority: clr beats load and en; load beats en.
    drive(0, 1, 16'h0042, 0, 16'h0000);
    drive(1, 1, 16'h1111, 1, 16'h0000);
    drive(0, 1, 16'h00A0, 1, 16'h00A1);

    // Terminal count, and load/clr do not raise tc_hit.
    drive(0, 1, 16'h0003, 0, 16'h0005);
    repeat (3) drive(0, 0, 16'h0000, 1, 16'h0005);
    drive(0, 1, 16'h0005, 0, 16'h0005);
    drive(1, 0, 16'h0000, 0, 16'h0000);

    // Asynchronous reset while the count is 0x1234 and tc_hit is high.
    drive(0, 1, 16'h1233, 0, 16'h1234);
    drive(0, 0, 16'h0000, 1, 16'h1234);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async", {13'd0, count, carry, overflow, tc_hit}, 32'd0);
    reset_hold();

    // Random stimulus, biased toward the signed and unsigned boundaries.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      c = (r < 4);
      l = (r >= 4 && r < 16);
      e = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       lv = 16'h7FFF - WIDTH'($urandom_range(0, 3));
        1:       lv = 16'hFFFF - WIDTH'($urandom_range(0, 3));
        default: lv = WIDTH'($urandom);
      endcase
      if ($urandom_range(0, 2) == 0) tv = WIDTH'((m_count + STEP) % MODV);
      else                           tv = WIDTH'($urandom);
      drive(c, l, lv, e, tv);
    end

    // Drain: the last queued entry is compared one edge after the final drive.
    drive(0, 0, 16'h0000, 0, 16'h0000);
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
